mouse_tile_decoder: RTL and testbench

MOUSE_TILE_DECODER -- requirements
Module: mouse_tile_decoder

---
 rtl/mouse_pkg.sv | 38 +++
 rtl/tile_divider.sv | 56 +++++
 rtl/mouse_tile_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_mouse_tile_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_pkg
// Description : Shared types and default board geometry for the mouse tile
//               decoder (state encoding, tile index type, span helper).
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

    // Conversion sequencer states
    typedef enum logic [2:0] {
        ST_CAPTURE = 3'd0,
        ST_DIV_X   = 3'd1,
        ST_DIV_Y   = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

    // Column/row index on a board of up to 31 tiles per side
    typedef logic [4:0] tile_idx_t;

    // Default board geometry (pixels / tiles)
    localparam int c_DEF_BOARD_X0 = 192;
    localparam int c_DEF_BOARD_Y0 = 96;
    localparam int c_DEF_TILE     = 32;
    localparam int c_DEF_COLS     = 16;
    localparam int c_DEF_ROWS     = 16;

    // True when pos lies in [base, base + count*tile)
    function automatic logic in_span(input logic [11:0] pos, input int base,
                                     input int count, input int tile);
        int p;
        p = int'({20'd0, pos});
        return (p >= base) && (p < base + count * tile);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_divider.sv
`default_nettype none
// ============================================================================
// Module      : tile_divider
// Description : Iterative divide-by-TILE using one subtraction per cycle.
//               Pulse i_start with the pixel offset; o_done rises once the
//               remainder drops below TILE, quotient = tiles crossed.
//               o_range reports whether the quotient is below i_limit.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_divider
    import mouse_pkg::*;
#(
    parameter int TILE = c_DEF_TILE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [11:0] i_value,
    input  tile_idx_t   i_limit,
    output logic        o_done,
    output tile_idx_t   o_quot,
    output logic        o_range
);

    localparam logic [11:0] c_TILE = 12'(TILE);

    logic [11:0] r_rem;
    tile_idx_t   r_quot;
    logic        r_busy;

    assign o_done  = r_busy && (r_rem < c_TILE);
    assign o_quot  = r_quot;
    assign o_range = (r_quot < i_limit);

    // Load on start, otherwise peel one tile per cycle until done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= 12'd0;
            r_quot <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_value;
            r_quot <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_rem >= c_TILE) begin
                r_rem  <= r_rem - c_TILE;
                r_quot <= r_quot + 5'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mouse_tile_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mouse_tile_decoder
// Description : Converts the pointer position into the board tile under it
//               and turns left/right click pulses into a valid/ready event
//               stream carrying the clicked tile. One shared divider is used
//               for X then Y.
//               Build option: define CLICK_HOLDOFF_EN to ignore click pulses
//               for 2^20 cycles after every accepted event.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_tile_decoder
    import mouse_pkg::*;
#(
    parameter int BOARD_X0 = c_DEF_BOARD_X0,
    parameter int BOARD_Y0 = c_DEF_BOARD_Y0,
    parameter int TILE     = c_DEF_TILE,
    parameter int COLS     = c_DEF_COLS,
    parameter int ROWS     = c_DEF_ROWS
) (
    input  logic        clk74MHz,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        left,
    input  logic        right,
    output tile_idx_t   hover_col,
    output tile_idx_t   hover_row,
    output logic        hover_valid,
    output logic        evt_valid,
    input  logic        evt_ready,
    output tile_idx_t   evt_col,
    output tile_idx_t   evt_row,
    output logic        evt_flag
);

    localparam logic [11:0] c_X0   = 12'(BOARD_X0);
    localparam logic [11:0] c_Y0   = 12'(BOARD_Y0);
    localparam tile_idx_t   c_COLS = 5'(COLS);
    localparam tile_idx_t   c_ROWS = 5'(ROWS);

    state_t      r_state;
    logic [11:0] r_ypos;
    logic        r_inside;
    tile_idx_t   r_col;
    tile_idx_t   r_row;
    logic        r_pend_l;
    logic        r_pend_r;

    logic        w_inside;
    logic        w_accept;
    logic        w_div_start;
    logic [11:0] w_div_value;
    tile_idx_t   w_div_limit;
    logic        w_div_done;
    tile_idx_t   w_div_quot;
    logic        w_div_range;
    logic        w_clr_l;
    logic        w_clr_r;
    logic        w_set_l;
    logic        w_set_r;

    assign w_inside = in_span(mouse_xpos, BOARD_X0, COLS, TILE) &&
                      in_span(mouse_ypos, BOARD_Y0, ROWS, TILE);
    assign w_accept = (r_state == ST_EMIT) && evt_ready;

    // Divider operands: X comes straight off the pins at capture, Y from the
    // captured copy so pointer motion mid-conversion is ignored.
    always_comb begin
        w_div_start = 1'b0;
        w_div_value = (r_state == ST_CAPTURE) ? (mouse_xpos - c_X0) : (r_ypos - c_Y0);
        w_div_limit = (r_state == ST_DIV_Y) ? c_ROWS : c_COLS;
        case (r_state)
            ST_CAPTURE: w_div_start = w_inside;
            ST_DIV_X:   w_div_start = w_div_done;
            default:    w_div_start = 1'b0;
        endcase
    end

    tile_divider #(
        .TILE (TILE)
    ) u_divider (
        .clk     (clk74MHz),
        .rst     (rst),
        .i_start (w_div_start),
        .i_value (w_div_value),
        .i_limit (w_div_limit),
        .o_done  (w_div_done),
        .o_quot  (w_div_quot),
        .o_range (w_div_range)
    );

    // Pending-flag clears at UPDATE: off-board drops both, else left first
    always_comb begin
        w_clr_l = 1'b0;
        w_clr_r = 1'b0;
        if (r_state == ST_UPDATE) begin
            if (!r_inside) begin
                w_clr_l = 1'b1;
                w_clr_r = 1'b1;
            end else if (r_pend_l) begin
                w_clr_l = 1'b1;
            end else begin
                w_clr_r = r_pend_r;
            end
        end
    end

`ifdef CLICK_HOLDOFF_EN
    logic [19:0] r_holdoff_cnt;
    logic        r_holdoff_act;

    // Quiet window of 2^20 cycles following each accepted event
    always_ff @(posedge clk74MHz) begin
        if (rst) begin
            r_holdoff_cnt <= 20'd0;
            r_holdoff_act <= 1'b0;
        end else if (w_accept) begin
            r_holdoff_cnt <= 20'd0;
            r_holdoff_act <= 1'b1;
        end else if (r_holdoff_act) begin
            r_holdoff_cnt <= r_holdoff_cnt + 20'd1;
            if (r_holdoff_cnt == 20'hFFFFF) begin
                r_holdoff_act <= 1'b0;
            end
        end
    end

    assign w_set_l = left  && !r_holdoff_act;
    assign w_set_r = right && !r_holdoff_act;
`else
    assign w_set_l = left;
    assign w_set_r = right;
`endif

    // Conversion sequencer with registered hover and event outputs
    always_ff @(posedge clk74MHz) begin
        if (rst) begin
            r_state     <= ST_CAPTURE;
            r_ypos      <= 12'd0;
            r_inside    <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_pend_l    <= 1'b0;
            r_pend_r    <= 1'b0;
            hover_col   <= '0;
            hover_row   <= '0;
            hover_valid <= 1'b0;
            evt_valid   <= 1'b0;
            evt_col     <= '0;
            evt_row     <= '0;
            evt_flag    <= 1'b0;
        end else begin
            // A pulse landing on the clearing cycle survives (set wins)
            r_pend_l <= (r_pend_l && !w_clr_l) || w_set_l;
            r_pend_r <= (r_pend_r && !w_clr_r) || w_set_r;

            case (r_state)
                ST_CAPTURE: begin
                    r_ypos   <= mouse_ypos;
                    r_inside <= w_inside;
                    r_state  <= w_inside ? ST_DIV_X : ST_UPDATE;
                end
                ST_DIV_X: begin
                    if (w_div_done) begin
                        r_col    <= w_div_quot;
                        r_inside <= r_inside && w_div_range;
                        r_state  <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (w_div_done) begin
                        r_row    <= w_div_quot;
                        r_inside <= r_inside && w_div_range;
                        r_state  <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    hover_valid <= r_inside;
                    if (r_inside) begin
                        hover_col <= r_col;
                        hover_row <= r_row;
                    end
                    if (r_inside && (r_pend_l || r_pend_r)) begin
                        evt_valid <= 1'b1;
                        evt_col   <= r_col;
                        evt_row   <= r_row;
                        evt_flag  <= !r_pend_l;
                        r_state   <= ST_EMIT;
                    end else begin
                        r_state   <= ST_CAPTURE;
                    end
                end
                ST_EMIT: begin
                    if (w_accept) begin
                        evt_valid <= 1'b0;
                        r_state   <= ST_CAPTURE;
                    end
                end
                default: r_state <= ST_CAPTURE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mouse_tile_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_tile_decoder
// Description : Self-checking bench for mouse_tile_decoder: vector table,
//               directed multi-cycle sequences and a randomized run against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_tile_decoder;

    localparam int c_X0 = 192;
    localparam int c_Y0 = 96;
    localparam int c_T  = 32;
    localparam int c_N  = 16;

    logic        clk74MHz = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic [4:0]  hover_col;
    logic [4:0]  hover_row;
    logic        hover_valid;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [4:0]  evt_col;
    logic [4:0]  evt_row;
    logic        evt_flag;

    int n_cmp = 0;
    int n_bad = 0;

    mouse_tile_decoder dut (
        .clk74MHz    (clk74MHz),
        .rst         (rst),
        .mouse_xpos  (mouse_xpos),
        .mouse_ypos  (mouse_ypos),
        .left        (left),
        .right       (right),
        .hover_col   (hover_col),
        .hover_row   (hover_row),
        .hover_valid (hover_valid),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_col     (evt_col),
        .evt_row     (evt_row),
        .evt_flag    (evt_flag)
    );

    always #5 clk74MHz = ~clk74MHz;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        int x;
        int y;
        int l;
        int r;
        int valid;
        int col;
        int row;
        int ev;
        int flag;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk74MHz);
        #1;
    endtask

    // Leaves the DUT so that the next edge is a CAPTURE cycle
    task automatic do_reset();
        rst   = 1'b1;
        left  = 1'b0;
        right = 1'b0;
        step();
        step();
        rst   = 1'b0;
    endtask

    function automatic void model_tile(input int x, input int y, output bit ins,
                                       output int c, output int r);
        ins = (x >= c_X0) && (x < c_X0 + c_N * c_T) &&
              (y >= c_Y0) && (y < c_Y0 + c_N * c_T);
        c = ins ? (x - c_X0) / c_T : 0;
        r = ins ? (y - c_Y0) / c_T : 0;
    endfunction

    function automatic int conv_len(input bit ins, input int c, input int r);
        return ins ? (c + r + 4) : 2;
    endfunction

    // One conversion from CAPTURE through the UPDATE edge, pulses on capture
    task automatic run_conv(input int x, input int y, input bit l, input bit r);
        bit ins;
        int c;
        int rw;
        int lat;
        model_tile(x, y, ins, c, rw);
        lat = conv_len(ins, c, rw);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        left  = l;
        right = r;
        step();
        left  = 1'b0;
        right = 1'b0;
        for (int k = 1; k < lat; k++) step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        lat = (v.valid != 0) ? (v.col + v.row + 4) : 2;
        do_reset();
        evt_ready  = 1'b1;
        mouse_xpos = 12'(v.x);
        mouse_ypos = 12'(v.y);
        left  = (v.l != 0);
        right = (v.r != 0);
        step();
        left  = 1'b0;
        right = 1'b0;
        for (int k = 1; k < lat - 1; k++) step();
        chk($sformatf("v%0d_pre_hover_valid", idx), int'(hover_valid), 0);
        chk($sformatf("v%0d_pre_evt_valid", idx), int'(evt_valid), 0);
        step();
        chk($sformatf("v%0d_hover_valid", idx), int'(hover_valid), v.valid);
        chk($sformatf("v%0d_hover_col", idx), int'(hover_col), v.col);
        chk($sformatf("v%0d_hover_row", idx), int'(hover_row), v.row);
        chk($sformatf("v%0d_evt_valid", idx), int'(evt_valid), v.ev);
        if (v.ev != 0) begin
            chk($sformatf("v%0d_evt_col", idx), int'(evt_col), v.col);
            chk($sformatf("v%0d_evt_row", idx), int'(evt_row), v.row);
            chk($sformatf("v%0d_evt_flag", idx), int'(evt_flag), v.flag);
        end
        step();
        chk($sformatf("v%0d_evt_done", idx), int'(evt_valid), 0);
    endtask

    initial begin
        vec_t vecs[10];
        bit   ins;
        int   c;
        int   r;
        int   lat;
        int   hc;
        int   hr;
        int   hv;
        bit   pl;
        bit   pr;
        bit   ev;
        bit   fl;
        bit   pul_l;
        bit   pul_r;
        bit   rdy;
        bit   accepted;
        int   x;
        int   y;

        //            x    y   l  r  val col row ev flag
        vecs[0] = '{200, 100, 0, 0, 1,  0,  0, 0, 0};
        vecs[1] = '{703, 607, 0, 0, 1, 15, 15, 0, 0};
        vecs[2] = '{300, 160, 1, 0, 1,  3,  2, 1, 0};
        vecs[3] = '{300, 160, 0, 1, 1,  3,  2, 1, 1};
        vecs[4] = '{192,  96, 1, 0, 1,  0,  0, 1, 0};
        vecs[5] = '{191,  96, 1, 0, 0,  0,  0, 0, 0};
        vecs[6] = '{704, 100, 0, 1, 0,  0,  0, 0, 0};
        vecs[7] = '{200, 608, 0, 1, 0,  0,  0, 0, 0};
        vecs[8] = '{223, 127, 0, 0, 1,  0,  0, 0, 0};
        vecs[9] = '{224, 128, 0, 1, 1,  1,  1, 1, 1};

        // Reset state
        do_reset();
        chk("reset_hover_valid", int'(hover_valid), 0);
        chk("reset_evt_valid", int'(evt_valid), 0);
        chk("reset_fields", int'({hover_col, hover_row, evt_col, evt_row, evt_flag}), 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Last tile, then one pixel past the edge: valid drops, indices held
        do_reset();
        evt_ready = 1'b1;
        run_conv(703, 607, 1'b0, 1'b0);
        chk("edge_in_valid", int'(hover_valid), 1);
        run_conv(704, 607, 1'b0, 1'b0);
        chk("edge_out_valid", int'(hover_valid), 0);
        chk("edge_out_col_held", int'(hover_col), 15);
        chk("edge_out_row_held", int'(hover_row), 15);

        // Simultaneous left+right: left event first, right after next conversion
        do_reset();
        evt_ready = 1'b1;
        run_conv(300, 160, 1'b1, 1'b1);
        chk("both_ev1_valid", int'(evt_valid), 1);
        chk("both_ev1_flag", int'(evt_flag), 0);
        step();
        chk("both_ev1_done", int'(evt_valid), 0);
        run_conv(300, 160, 1'b0, 1'b0);
        chk("both_ev2_valid", int'(evt_valid), 1);
        chk("both_ev2_flag", int'(evt_flag), 1);
        chk("both_ev2_tile", int'({evt_col, evt_row}), int'({5'd3, 5'd2}));
        step();
        run_conv(300, 160, 1'b0, 1'b0);
        chk("both_no_third", int'(evt_valid), 0);

        // Backpressure: fields stable while the pointer moves away
        do_reset();
        evt_ready = 1'b0;
        run_conv(300, 160, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            mouse_xpos = 12'(300 + (i + 1) * 4);
            step();
            chk("stall_hold", int'({evt_valid, evt_col, evt_row, evt_flag}),
                int'({1'b1, 5'd3, 5'd2, 1'b0}));
        end
        evt_ready = 1'b1;
        step();
        chk("stall_release", int'(evt_valid), 0);
        run_conv(500, 160, 1'b0, 1'b0);
        chk("stall_new_col", int'(hover_col), 9);
        chk("stall_new_valid", int'(hover_valid), 1);

        // Off-board right click is dropped
        do_reset();
        evt_ready = 1'b1;
        run_conv(100, 160, 1'b0, 1'b1);
        chk("off_no_evt", int'(evt_valid), 0);
        run_conv(300, 160, 1'b0, 1'b0);
        chk("off_pend_dropped", int'(evt_valid), 0);
        chk("off_then_hover", int'(hover_col), 3);

        // Reset during EMIT drops the event
        evt_ready = 1'b0;
        run_conv(300, 160, 1'b1, 1'b0);
        chk("rst_emit_pre", int'(evt_valid), 1);
        rst = 1'b1;
        step();
        chk("rst_emit_dropped", int'(evt_valid), 0);
        chk("rst_emit_hover", int'(hover_valid), 0);
        rst = 1'b0;

        // Randomized run against the transaction-level model
        do_reset();
        hv = 0; hc = 0; hr = 0;
        pl = 1'b0; pr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            x = int'($urandom_range(150, 750));
            y = int'($urandom_range(60, 650));
            model_tile(x, y, ins, c, r);
            lat = conv_len(ins, c, r);
            ev = 1'b0;
            fl = 1'b0;
            for (int k = 0; k < lat; k++) begin
                if (k == 0) begin
                    mouse_xpos = 12'(x);
                    mouse_ypos = 12'(y);
                end else if ($urandom_range(0, 3) == 0) begin
                    mouse_xpos = 12'($urandom_range(0, 1023));
                    mouse_ypos = 12'($urandom_range(0, 1023));
                end
                pul_l = ($urandom_range(0, 7) == 0);
                pul_r = ($urandom_range(0, 7) == 0);
                left  = pul_l;
                right = pul_r;
                evt_ready = 1'($urandom_range(0, 1));
                if (k == lat - 1) begin
                    ev = ins && (pl || pr);
                    fl = !pl;
                    if (!ins) begin
                        pl = 1'b0;
                        pr = 1'b0;
                    end else if (pl) begin
                        pl = 1'b0;
                    end else begin
                        pr = 1'b0;
                    end
                end
                pl = pl | pul_l;
                pr = pr | pul_r;
                step();
                if (k == lat - 2) begin
                    chk("rnd_pre_hover", int'({hover_valid, hover_col, hover_row}),
                        int'({1'(hv), 5'(hc), 5'(hr)}));
                    chk("rnd_pre_evt", int'(evt_valid), 0);
                end
            end
            hv = ins ? 1 : 0;
            if (ins) begin
                hc = c;
                hr = r;
            end
            chk("rnd_hover", int'({hover_valid, hover_col, hover_row}),
                int'({1'(hv), 5'(hc), 5'(hr)}));
            chk("rnd_evt_valid", int'(evt_valid), int'(ev));
            if (ev) begin
                chk("rnd_evt_fields", int'({evt_col, evt_row, evt_flag}),
                    int'({5'(c), 5'(r), fl}));
                accepted = 1'b0;
                for (int w = 0; w < 40 && !accepted; w++) begin
                    rdy = (w >= 30) ? 1'b1 : ($urandom_range(0, 2) == 0);
                    evt_ready = rdy;
                    pul_l = ($urandom_range(0, 7) == 0);
                    pul_r = ($urandom_range(0, 7) == 0);
                    left  = pul_l;
                    right = pul_r;
                    pl = pl | pul_l;
                    pr = pr | pul_r;
                    mouse_xpos = 12'($urandom_range(0, 1023));
                    step();
                    if (rdy) begin
                        chk("rnd_evt_accept", int'(evt_valid), 0);
                        accepted = 1'b1;
                    end else begin
                        chk("rnd_evt_hold", int'({evt_valid, evt_col, evt_row, evt_flag}),
                            int'({1'b1, 5'(c), 5'(r), fl}));
                    end
                end
            end
        end
        left  = 1'b0;
        right = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
